// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
//   One BUS-style request/grant port: request with write strobe, address and
//   write data going one way, grant and read data coming back.
//   master : the side that issues requests (drives req/wr/addr/dout)
//   slave  : the side that answers requests (drives grant/din)
// ---------------------------------------------------------------------------
interface bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [15:0] addr;
  logic [63:0] dout;
  logic        grant;
  logic [63:0] din;

  modport master (
    output req, wr, addr, dout,
    input  grant, din
  );

  modport slave (
    input  req, wr, addr, dout,
    output grant, din
  );
endinterface

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Two-master arbiter in front of the system BUS master port. M0 (core) and
//   M1 (DMA/loader) each get a private BUS-style port; exactly one of them
//   owns the real bus at a time. Contention is resolved round-robin, and an
//   optional hold limit preempts an owner that keeps the bus while the other
//   master is waiting. Every change of owner passes through a one-cycle
//   release state so the BUS sees req low before the next owner appears.
//
// Parameters
//   MAX_HOLD  cycles an owner may keep the bus while the other requests
//             (0 = unlimited)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports
//   clk    in   system clock, all state on rising edge
//   reset  in   asynchronous active-high reset
//   m0     slave modport, master M0 private port
//   m1     slave modport, master M1 private port
//   bus    master modport, towards the system BUS
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  m0,
  bus_arbiter_if.slave  m1,
  bus_arbiter_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  // Counter value at which a contended owner is released.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam bit               HOLD_EN   = (MAX_HOLD != 0);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             last;
  logic             last_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_nxt;
  logic             own_req;
  logic             other_req;

  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    hold_cnt_nxt = hold_cnt;
    own_req      = (state == S_OWN1) ? m1.req : m0.req;
    other_req    = (state == S_OWN1) ? m0.req : m1.req;

    case (state)
      S_IDLE: begin
        // M0 wins when alone, or on contention when M1 was served last.
        if (m0.req && (!m1.req || last)) begin
          state_nxt    = S_OWN0;
          last_nxt     = 1'b0;
          hold_cnt_nxt = '0;
        end else if (m1.req) begin
          state_nxt    = S_OWN1;
          last_nxt     = 1'b1;
          hold_cnt_nxt = '0;
        end
      end

      S_OWN0, S_OWN1: begin
        // Request drop takes priority, so a drop coinciding with hold
        // expiry still produces a single release.
        if (!own_req) begin
          state_nxt = S_REL;
        end else if (other_req) begin
          if (HOLD_EN && (hold_cnt == HOLD_LAST)) begin
            state_nxt = S_REL;
          end else if (HOLD_EN) begin
            hold_cnt_nxt = hold_cnt + 1'b1;
          end
        end else begin
          hold_cnt_nxt = '0;
        end
      end

      S_REL: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      last     <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Output mux is purely combinational from state, so an asynchronous
  // reset drops bus_req and both grants immediately.
  always_comb begin
    bus.req  = 1'b0;
    bus.wr   = 1'b0;
    bus.addr = '0;
    bus.dout = '0;
    m0.grant = 1'b0;
    m0.din   = '0;
    m1.grant = 1'b0;
    m1.din   = '0;

    case (state)
      S_OWN0: begin
        bus.req  = m0.req;
        bus.wr   = m0.wr;
        bus.addr = m0.addr;
        bus.dout = m0.dout;
        m0.grant = bus.grant;
        m0.din   = bus.din;
      end
      S_OWN1: begin
        bus.req  = m1.req;
        bus.wr   = m1.wr;
        bus.addr = m1.addr;
        bus.dout = m1.dout;
        m1.grant = bus.grant;
        m1.din   = bus.din;
      end
      default: begin
      end
    endcase
  end

endmodule
